// File: rtl/class_hvec_search.sv
// class_hvec_search: associative search returning the class hypervector nearest to a query
module class_hvec_search #(
   parameter int DI_PARALLEL_W_BITS = 64,
   parameter int N_CLASSES          = 8,
   parameter int N_FRAMES           = 3,
   parameter int CLASS_ID_W         = 3,
   parameter int FRAME_IDX_W        = 2,
   parameter int DIST_W             = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          query_valid,
   output logic                          query_ready,
   input  logic [DI_PARALLEL_W_BITS-1:0] query_data,
   output logic [CLASS_ID_W-1:0]         frame_id,
   output logic [FRAME_IDX_W-1:0]        frame_index,
   input  logic [DI_PARALLEL_W_BITS-1:0] class_vec_in,
   output logic                          result_valid,
   input  logic                          result_ready,
   output logic [CLASS_ID_W-1:0]         result_class,
   output logic [DIST_W-1:0]             result_dist
);
   typedef enum logic [1:0] {IDLE, SWEEP, SELECT, RESULT} state_t;
   state_t state, state_nxt;
   logic [DI_PARALLEL_W_BITS-1:0] q_reg;
   logic [FRAME_IDX_W-1:0] frame_cnt;
   logic [CLASS_ID_W-1:0] class_cnt, best_class;
   logic [DIST_W-1:0] best_dist, pop;
   logic [DIST_W-1:0] acc [N_CLASSES];
   logic last_class, last_frame;
   assign pop = DIST_W'($countones(q_reg ^ class_vec_in));
   assign last_class = class_cnt == CLASS_ID_W'(N_CLASSES - 1);
   assign last_frame = frame_cnt == FRAME_IDX_W'(N_FRAMES - 1);
   // state register
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= state_nxt;
   // next state and handshake/generator outputs
   always_comb begin
      state_nxt = state;
      query_ready = 1'b0;
      result_valid = 1'b0;
      result_class = '0;
      result_dist = '0;
      frame_id = '0;
      frame_index = frame_cnt;
      case (state)
         IDLE: begin
            query_ready = 1'b1;
            state_nxt = query_valid ? SWEEP : IDLE;
         end
         SWEEP: begin
            frame_id = class_cnt;
            state_nxt = last_class ? (last_frame ? SELECT : IDLE) : SWEEP;
         end
         SELECT: state_nxt = last_class ? RESULT : SELECT;
         RESULT: begin
            result_valid = 1'b1;
            result_class = best_class;
            result_dist = best_dist;
            state_nxt = result_ready ? IDLE : RESULT;
         end
      endcase
   end
   // datapath: frame latch, per-class distance accumulation, argmin scan
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         q_reg <= '0;
         frame_cnt <= '0;
         class_cnt <= '0;
         best_class <= '0;
         best_dist <= '0;
         for (int i = 0; i < N_CLASSES; i++) acc[i] <= '0;
      end else
         case (state)
            IDLE:
               if (query_valid) begin
                  q_reg <= query_data;
                  class_cnt <= '0;
                  if (frame_cnt == '0)
                     for (int i = 0; i < N_CLASSES; i++) acc[i] <= '0;
               end
            SWEEP: begin
               acc[class_cnt] <= acc[class_cnt] + pop;
               class_cnt <= class_cnt + 1'b1;
               if (last_class && last_frame) begin
                  class_cnt <= '0;
                  best_dist <= '1;
                  best_class <= '0;
               end else if (last_class)
                  frame_cnt <= frame_cnt + 1'b1;
            end
            SELECT: begin
               if (acc[class_cnt] < best_dist) begin
                  best_dist <= acc[class_cnt];
                  best_class <= class_cnt;
               end
               class_cnt <= class_cnt + 1'b1;
            end
            RESULT:
               if (result_ready) frame_cnt <= '0;
         endcase
endmodule

// File: tb/tb_class_hvec_search.sv
// tb_class_hvec_search: directed vector bench for class_hvec_search with a stub class ROM
module tb_class_hvec_search;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic query_valid = 1'b0;
   logic query_ready;
   logic [63:0] query_data = '0;
   logic [2:0] frame_id;
   logic [1:0] frame_index;
   logic [63:0] class_vec_in;
   logic result_valid;
   logic result_ready = 1'b0;
   logic [2:0] result_class;
   logic [7:0] result_dist;
   logic tie = 1'b0;
   int passed = 0;
   int total = 0;
   int ecnt = 0;

   typedef struct {
      int cls;
      logic [63:0] m0, m1, m2;
      bit tie;
      int gap, hold, ecls, edist, elat;
   } vec_t;
   vec_t v [7];

   class_hvec_search dut (
      .clk(clk), .rst(rst), .query_valid(query_valid), .query_ready(query_ready),
      .query_data(query_data), .frame_id(frame_id), .frame_index(frame_index),
      .class_vec_in(class_vec_in), .result_valid(result_valid), .result_ready(result_ready),
      .result_class(result_class), .result_dist(result_dist)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] gen(input int c, input int f);
      logic [63:0] k, h;
      k = 64'(c * 3 + f + 1);
      h = k * 64'h9E3779B97F4A7C15;
      return h ^ (h >> 29);
   endfunction

   assign class_vec_in = gen((tie && frame_id == 3'd5) ? 2 : int'(frame_id), int'(frame_index));

   task automatic tick;
      @(posedge clk);
      #1;
      ecnt++;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic wait_ready;
      int b = 0;
      while (!query_ready && b < 100) begin
         tick;
         b++;
      end
      chk("query_ready_wait", query_ready, 1);
   endtask

   task automatic run(input vec_t t);
      int t0, b, lat;
      logic [63:0] m;
      logic [2:0] hc;
      logic [7:0] hd;
      tie = t.tie;
      t0 = 0;
      for (int f = 0; f < 3; f++) begin
         wait_ready;
         if (f > 0) repeat (t.gap) tick;
         m = f == 0 ? t.m0 : f == 1 ? t.m1 : t.m2;
         query_valid = 1'b1;
         query_data = gen(t.cls, f) ^ m;
         tick;
         query_valid = 1'b0;
         if (f == 0) t0 = ecnt;
         chk("sweep_frame_index", frame_index, 64'(f));
         chk("sweep_query_ready", query_ready, 0);
      end
      b = 0;
      while (!result_valid && b < 200) begin
         tick;
         b++;
      end
      chk("result_valid_timeout", result_valid, 1);
      lat = ecnt - t0 + 1;
      chk("result_latency", 64'(lat), 64'(t.elat));
      chk("result_class", result_class, 64'(t.ecls));
      chk("result_dist", result_dist, 64'(t.edist));
      chk("result_query_ready", query_ready, 0);
      hc = result_class;
      hd = result_dist;
      for (int i = 0; i < t.hold; i++) begin
         tick;
         chk("hold_stable", {result_valid, query_ready, result_class, result_dist},
             {1'b1, 1'b0, hc, hd});
      end
      result_ready = 1'b1;
      tick;
      result_ready = 1'b0;
      chk("handshake_valid_low", result_valid, 0);
      chk("handshake_query_ready", query_ready, 1);
      chk("handshake_frame_index", frame_index, 0);
      tie = 1'b0;
   endtask

   initial begin
      v[0] = '{6, 64'h0, 64'h0, 64'h0, 1'b0, 0, 20, 6, 0, 35};
      v[1] = '{3, 64'h0, 64'h1F, 64'h0000_0300_0000_0000, 1'b0, 0, 0, 3, 7, 35};
      v[2] = '{2, 64'h0, 64'h0, 64'h0, 1'b1, 0, 0, 2, 0, 35};
      v[3] = '{3, 64'h0, 64'h1F, 64'h0000_0300_0000_0000, 1'b0, 4, 0, 3, 7, 43};
      v[4] = '{0, 64'h0, 64'h0, 64'h0, 1'b0, 0, 0, 0, 0, 35};
      v[5] = '{7, 64'hFFF0_0000_0000_0000, 64'h0, 64'h0, 1'b0, 0, 0, 7, 12, 35};
      v[6] = '{4, 64'h8000_0000_0000_0001, 64'h0, 64'h0000_0000_00F0_0000, 1'b0, 0, 0, 4, 6, 35};
      #2;
      chk("reset_outputs", {query_ready, result_valid, result_class, result_dist, frame_id, frame_index},
          {1'b1, 1'b0, 3'd0, 8'd0, 3'd0, 2'd0});
      tick;
      tick;
      rst = 1'b0;
      tick;
      for (int i = 0; i < 7; i++) run(v[i]);
      // abort a query during the sweep of frame 1
      query_valid = 1'b1;
      query_data = gen(5, 0);
      tick;
      query_valid = 1'b0;
      wait_ready;
      query_valid = 1'b1;
      query_data = gen(5, 1) ^ 64'hFF;
      tick;
      query_valid = 1'b0;
      tick;
      tick;
      chk("mid_sweep_frame_index", frame_index, 1);
      #3 rst = 1'b1;
      #1;
      chk("async_reset_outputs",
          {query_ready, result_valid, result_class, result_dist, frame_id, frame_index},
          {1'b1, 1'b0, 3'd0, 8'd0, 3'd0, 2'd0});
      tick;
      rst = 1'b0;
      tick;
      run(v[4]);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
